// File: rtl/sigmoid_pwl_unit.sv
// Multi-lane sigmoid / tanh / sigmoid-derivative unit using a shift-and-add
// piecewise-linear (PLAN) approximation, three register stages, valid/ready streaming.
`timescale 1ns/1ps
module sigmoid_pwl_unit #(
  parameter int BITWIDTH = 18,
  parameter int QM       = 11,
  parameter int CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_mode,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data
);
  // y and s live in [0, ONE], so QM+1 unsigned bits hold them exactly.
  localparam int YW = QM + 1;
  localparam int PW = 2 * YW;

  localparam logic [BITWIDTH-1:0] MAXPOS  = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] MINNEG  = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0] SEG1_LO = BITWIDTH'(1) << QM;
  localparam logic [BITWIDTH-1:0] SEG2_LO = BITWIDTH'(19) << (QM - 3);
  localparam logic [BITWIDTH-1:0] SEG3_LO = BITWIDTH'(5) << QM;

  localparam logic [YW-1:0] ONE  = YW'(1) << QM;
  localparam logic [YW-1:0] C_B0 = YW'(1) << (QM - 1);
  localparam logic [YW-1:0] C_B1 = YW'(5) << (QM - 3);
  localparam logic [YW-1:0] C_B2 = YW'(27) << (QM - 5);

  // Stage 1: optional saturating doubling (tanh), then sign/magnitude split.
  function automatic logic [BITWIDTH:0] f_stage1(input logic [1:0] mode,
                                                 input logic [BITWIDTH-1:0] x);
    logic [BITWIDTH-1:0] xp;
    logic [BITWIDTH-1:0] a;
    xp = x;
    if (mode == 2'b01) begin
      if (x[BITWIDTH-1] != x[BITWIDTH-2]) xp = x[BITWIDTH-1] ? MINNEG : MAXPOS;
      else xp = {x[BITWIDTH-2:0], 1'b0};
    end
    if (!xp[BITWIDTH-1]) a = xp;
    else if (xp == MINNEG) a = MAXPOS;
    else a = -xp;
    return {xp[BITWIDTH-1], a};
  endfunction

  function automatic logic [YW-1:0] f_plan(input logic [BITWIDTH-1:0] a);
    if (a >= SEG3_LO) return ONE;
    else if (a >= SEG2_LO) return YW'(a >> 5) + C_B2;
    else if (a >= SEG1_LO) return YW'(a >> 3) + C_B1;
    else return YW'(a >> 2) + C_B0;
  endfunction

  function automatic logic [BITWIDTH-1:0] f_finish(input logic [1:0] mode,
                                                   input logic sign,
                                                   input logic [YW-1:0] y);
    logic [YW-1:0] s;
    logic [YW-1:0] sc;
    logic [YW:0]   t;
    logic [PW-1:0] p;
    s  = sign ? ONE - y : y;
    sc = ONE - s;
    t  = {s, 1'b0} - {1'b0, ONE};
    p  = {{YW{1'b0}}, s} * {{YW{1'b0}}, sc};
    case (mode)
      2'b01:   return {{(BITWIDTH-YW-1){t[YW]}}, t};
      2'b10:   return {{(BITWIDTH-YW){1'b0}}, p[QM +: YW]};
      default: return {{(BITWIDTH-YW){1'b0}}, s};
    endcase
  endfunction

  logic                                r_v1, r_v2, r_v3;
  logic [1:0]                          r_m1, r_m2;
  logic [CHANNELS-1:0]                 r_sign1, r_sign2;
  logic [CHANNELS-1:0][BITWIDTH-1:0]   r_a1;
  logic [CHANNELS-1:0][YW-1:0]         r_y2;
  logic [CHANNELS*BITWIDTH-1:0]        r_out3;

  logic                                w_en;
  logic [CHANNELS-1:0]                 w_sign1;
  logic [CHANNELS-1:0][BITWIDTH-1:0]   w_a1;
  logic [CHANNELS-1:0][YW-1:0]         w_y2;
  logic [CHANNELS*BITWIDTH-1:0]        w_out3;

  // Handshake: a vector transfers on a rising edge where valid and ready are
  // both high. The whole pipe advances whenever the output slot is empty or
  // being drained; otherwise every stage holds and the output stays stable.
  assign w_en      = !r_v3 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign out_data  = r_out3;

  always_comb begin
    w_sign1 = '0;
    w_a1    = '0;
    w_y2    = '0;
    w_out3  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      {w_sign1[i], w_a1[i]} = f_stage1(in_mode, in_data[i*BITWIDTH +: BITWIDTH]);
      w_y2[i] = f_plan(r_a1[i]);
      w_out3[i*BITWIDTH +: BITWIDTH] = f_finish(r_m2, r_sign2[i], r_y2[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_m1    <= '0;
      r_m2    <= '0;
      r_sign1 <= '0;
      r_sign2 <= '0;
      r_a1    <= '0;
      r_y2    <= '0;
      r_out3  <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      r_m1    <= in_mode;
      r_m2    <= r_m1;
      r_sign1 <= w_sign1;
      r_a1    <= w_a1;
      r_sign2 <= r_sign1;
      r_y2    <= w_y2;
      r_out3  <= w_out3;
    end
  end
endmodule

// File: tb/tb_sigmoid_pwl_unit.sv
// Scoreboard bench for sigmoid_pwl_unit: directed spot values, random traffic
// with backpressure and bubbles, and a mid-stream reset.
`timescale 1ns/1ps
module tb_sigmoid_pwl_unit;
  localparam int BW   = 18;
  localparam int QM   = 11;
  localparam int CH   = 4;
  localparam int W    = CH * BW;
  localparam int ONE  = 1 << QM;
  localparam int XMAX = (1 << (BW - 1)) - 1;
  localparam int XMIN = -(1 << (BW - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_mode = 2'b00;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  bit           strict_q[$];

  sigmoid_pwl_unit #(.BITWIDTH(BW), .QM(QM), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: real-number rules evaluated with integer arithmetic.
  function automatic int ref_lane(input int mode, input int x);
    int xp, a, y, s;
    bit neg;
    xp = x;
    if (mode == 1) begin
      xp = 2 * x;
      if (xp > XMAX) xp = XMAX;
      if (xp < XMIN) xp = XMIN;
    end
    neg = (xp < 0);
    a = neg ? -xp : xp;
    if (a > XMAX) a = XMAX;
    if (a >= 5 * ONE) y = ONE;
    else if (8 * a >= 19 * ONE) y = a / 32 + (27 * ONE) / 32;
    else if (a >= ONE) y = a / 8 + (5 * ONE) / 8;
    else y = a / 4 + ONE / 2;
    s = neg ? ONE - y : y;
    case (mode)
      1:       return 2 * s - ONE;
      2:       return (s * (ONE - s)) / ONE;
      default: return s;
    endcase
  endfunction

  function automatic logic [W-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [W-1:0] r;
    r = '0;
    r[0*BW +: BW] = BW'(v0);
    r[1*BW +: BW] = BW'(v1);
    r[2*BW +: BW] = BW'(v2);
    r[3*BW +: BW] = BW'(v3);
    return r;
  endfunction

  function automatic int rand_x();
    int sel;
    int corners[15] = '{0, -1, 1, 2047, 2048, 4863, 4864, 10239, 10240,
                        -131072, 131071, 65535, 65536, -65536, -65537};
    sel = $urandom_range(0, 4);
    if (sel == 0) return corners[$urandom_range(0, 14)];
    if (sel <= 2) return int'($urandom_range(0, 24576)) - 12288;
    return int'($urandom_range(0, 262143)) + XMIN;
  endfunction

  task automatic gen_rand(input int mode, output logic [1:0] m,
                          output logic [W-1:0] d, output logic [W-1:0] e);
    int x[CH];
    for (int i = 0; i < CH; i++) x[i] = rand_x();
    m = 2'(mode);
    d = pack4(x[0], x[1], x[2], x[3]);
    e = pack4(ref_lane(mode, x[0]), ref_lane(mode, x[1]),
              ref_lane(mode, x[2]), ref_lane(mode, x[3]));
  endtask

  // One input cycle: drive just after the falling edge, decide acceptance once settled.
  task automatic drive_cycle(input logic v, input logic [1:0] m, input logic [W-1:0] d,
                             input logic ordy, input logic [W-1:0] e, input bit strict,
                             output bit acc);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_mode   = m;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      exp_q.push_back(e);
      lat_q.push_back(cyc);
      strict_q.push_back(strict);
    end
  endtask

  task automatic send_vec(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] e,
                          input bit strict, input bit rand_ordy);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 100) begin
      drive_cycle(1'b1, m, d, rand_ordy ? ($urandom_range(0, 3) != 0) : 1'b1, e, strict, acc);
      tries++;
    end
    n_checks++;
    if (!acc) begin
      n_errors++;
      $display("FAIL accept_timeout: in_ready never high in %0d cycles, required high", tries);
    end
  endtask

  task automatic directed(input logic [1:0] m, input int x0, input int x1, input int x2,
                          input int x3, input int e0, input int e1, input int e2, input int e3);
    send_vec(m, pack4(x0, x1, x2, x3), pack4(e0, e1, e2, e3), 1'b1, 1'b0);
  endtask

  task automatic drain();
    bit acc;
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 60) begin
      drive_cycle(1'b0, 2'b00, '0, 1'b1, '0, 1'b0, acc);
      budget++;
    end
    drive_cycle(1'b0, 2'b00, '0, 1'b1, '0, 1'b0, acc);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results still outstanding, required 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
      strict_q.delete();
    end
  endtask

  // Monitor: checks every output transfer against the scoreboard.
  bit           prev_stall = 0;
  logic [W-1:0] prev_data = '0;
  initial begin
    logic [W-1:0] e;
    int           lat;
    bit           strict;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        n_checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
          n_errors++;
          $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
        end
        if (prev_stall) begin
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== prev_data) begin
            n_errors++;
            $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                     out_valid, out_data, prev_data);
          end
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output: got %h, required no output", out_data);
          end else begin
            e = exp_q.pop_front();
            lat = lat_q.pop_front();
            strict = strict_q.pop_front();
            if (out_data !== e) begin
              n_errors++;
              $display("FAIL data: got %h, required %h", out_data, e);
            end
            if (strict) begin
              n_checks++;
              if (cyc - lat != 3) begin
                n_errors++;
                $display("FAIL latency: got %0d cycles, required 3", cyc - lat);
              end
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   m;
    logic [W-1:0] d, e;
    bit           acc;
    int           sent, c;

    @(negedge clk);
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got valid=%b data=%h, required 0/0", out_valid, out_data);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got %b, required 1", in_ready);
    end

    directed(2'b00, 0, 2048, -2048, 6144, 1024, 1536, 512, 1920);
    directed(2'b00, 12288, -131072, 4863, 4864, 2048, 0, 1887, 1880);
    directed(2'b00, 10239, 10240, 2047, 2048, 2047, 2048, 1535, 1536);
    directed(2'b01, 1024, 0, -131072, 131071, 1024, 0, -2048, 2048);
    directed(2'b10, 0, 2048, -12288, 0, 512, 384, 0, 512);
    directed(2'b11, 0, 2048, -2048, 6144, 1024, 1536, 512, 1920);
    drain();

    for (int i = 0; i < 16; i++) begin
      gen_rand((i % 4 == 3) ? 3 : ((i % 2 == 1) ? 2 : 0), m, d, e);
      send_vec(m, d, e, 1'b1, 1'b0);
    end
    drain();

    sent = 0;
    c = 0;
    while (sent < 10 && c < 100) begin
      gen_rand($urandom_range(0, 3), m, d, e);
      drive_cycle(1'b1, m, d, !(c >= 4 && c < 9), e, 1'b0, acc);
      if (acc) sent++;
      c++;
    end
    drain();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0)
        drive_cycle(1'b0, 2'(i), '1, ($urandom_range(0, 3) != 0), '0, 1'b0, acc);
      gen_rand($urandom_range(0, 3), m, d, e);
      send_vec(m, d, e, 1'b0, 1'b1);
    end
    drain();

    for (int i = 0; i < 3; i++) begin
      gen_rand(i, m, d, e);
      send_vec(m, d, e, 1'b1, 1'b0);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL prereset_full: got out_valid=%b, required 1", out_valid);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got valid=%b data=%h, required 0/0", out_valid, out_data);
    end
    exp_q.delete();
    lat_q.delete();
    strict_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) drive_cycle(1'b0, 2'b00, '0, 1'b1, '0, 1'b0, acc);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset: got valid=%b ready=%b, required 0/1", out_valid, in_ready);
    end
    gen_rand(1, m, d, e);
    send_vec(m, d, e, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
